// File: rtl/birthday_seq_display.sv
// -----------------------------------------------------------------------------
// birthday_seq_display
//   Programmable digit sequencer. Holds DIGITS writable digit slots and presents
//   them one at a time, stepping every PRESCALE clocks. It can step up or down
//   and can run one pass or loop. This block replaces the fixed 3-bit birthday
//   counter/lookup pair that drove the board display.
//
//   Optional feature: define SEG7_EN to add a registered 7-segment output
//   (seg[6:0], active-high, bit order g..a). Without SEG7_EN the seg port and
//   the decoder do not exist.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   synchronous reset, active-high, overrides all other inputs
//   wr_en     in   write wr_data into slot wr_addr (writes to slots >= DIGITS are dropped)
//   wr_addr   in   [IDX_W] slot to write
//   wr_data   in   [DW]    digit value to write
//   start     in   begin a sequence (ignored while busy)
//   stop      in   abort the sequence and go idle (wins over start)
//   dir       in   0 = ascending, 1 = descending; captured at start
//   loop      in   1 = wrap and repeat at the end of a pass; checked at each pass end
//   out       out  [DW]    digit currently presented
//   idx       out  [IDX_W] slot index of the digit on out
//   out_valid out  one-cycle pulse when a new digit appears on out
//   busy      out  high while running
//   done      out  one-cycle pulse when a one-shot pass completes
//   seg       out  [7] 7-segment code of out (SEG7_EN only)
// -----------------------------------------------------------------------------
module birthday_seq_display #(
   parameter int DIGITS   = 8,
   parameter int DW       = 4,
   parameter int IDX_W    = 3,
   parameter int PRESCALE = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [DW-1:0]    wr_data,
   input  logic             start,
   input  logic             stop,
   input  logic             dir,
   input  logic             loop,
   output logic [DW-1:0]    out,
   output logic [IDX_W-1:0] idx,
   output logic             out_valid,
   output logic             busy,
   output logic             done
`ifdef SEG7_EN
   ,
   output logic [6:0]       seg
`endif
);

   localparam int                PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0]   PS_ZERO  = {PS_W{1'b0}};
   localparam logic [PS_W-1:0]   PS_ONE   = PS_W'(1'b1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1'b1);
   // One extra bit so DIGITS itself is representable when 2**IDX_W == DIGITS.
   localparam logic [IDX_W:0]    DIGITS_X = (IDX_W + 1)'(DIGITS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DW-1:0]     mem_q [DIGITS];
   logic [PS_W-1:0]   ps_q, ps_d;
   logic              dir_q, dir_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DW-1:0]     out_q, out_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              launch_s;
   logic              step_s;
   logic              at_last_s;
   logic [IDX_W-1:0]  start_idx_s;
   logic [IDX_W-1:0]  nxt_idx_s;
   logic              wr_ok_s;

`ifdef SEG7_EN
   logic [6:0]        seg_q, seg_d;

   // 7-segment glyph for the low nibble, bit order g..a, hex letters A b C d E F.
   function automatic logic [6:0] seg7_f(input logic [3:0] v);
      case (v)
         4'h0:    seg7_f = 7'h3F;
         4'h1:    seg7_f = 7'h06;
         4'h2:    seg7_f = 7'h5B;
         4'h3:    seg7_f = 7'h4F;
         4'h4:    seg7_f = 7'h66;
         4'h5:    seg7_f = 7'h6D;
         4'h6:    seg7_f = 7'h7D;
         4'h7:    seg7_f = 7'h07;
         4'h8:    seg7_f = 7'h7F;
         4'h9:    seg7_f = 7'h6F;
         4'hA:    seg7_f = 7'h77;
         4'hB:    seg7_f = 7'h7C;
         4'hC:    seg7_f = 7'h39;
         4'hD:    seg7_f = 7'h5E;
         4'hE:    seg7_f = 7'h79;
         4'hF:    seg7_f = 7'h71;
         default: seg7_f = 7'h3F;
      endcase
   endfunction

   // Decode the digit being loaded so seg changes on the same edge as out.
   always_comb begin
      seg_d = seg7_f(4'(out_d));
   end
`endif

   // Index bookkeeping: where a pass starts, whether we sit on its last slot,
   // and the following slot. Wrapping is modulo DIGITS, not 2**IDX_W.
   always_comb begin
      start_idx_s = dir ? IDX_LAST : IDX_ZERO;
      at_last_s   = dir_q ? (idx_q == IDX_ZERO) : (idx_q == IDX_LAST);
      if (at_last_s) begin
         nxt_idx_s = dir_q ? IDX_LAST : IDX_ZERO;
      end else if (dir_q) begin
         nxt_idx_s = idx_q - IDX_ONE;
      end else begin
         nxt_idx_s = idx_q + IDX_ONE;
      end
      wr_ok_s = wr_en && ({1'b0, wr_addr} < DIGITS_X);
   end

   // Next-state logic; stop wins over start, start is ignored while running.
   always_comb begin
      state_d  = state_q;
      launch_s = 1'b0;
      step_s   = 1'b0;
      case (state_q)
         S_RUN: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (ps_q == PS_LAST) begin
               step_s = 1'b1;
               if (at_last_s && !loop) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_IDLE, S_DONE: begin
            if (start && !stop) begin
               state_d  = S_RUN;
               launch_s = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output/datapath next values. Slots are read from the registered array,
   // so a write landing on the slot being loaded shows the old digit.
   always_comb begin
      idx_d   = idx_q;
      out_d   = out_q;
      dir_d   = dir_q;
      ps_d    = PS_ZERO;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      if (launch_s) begin
         idx_d   = start_idx_s;
         out_d   = mem_q[start_idx_s];
         dir_d   = dir;
         valid_d = 1'b1;
         busy_d  = 1'b1;
      end else if (state_d == S_RUN) begin
         busy_d = 1'b1;
         if (step_s) begin
            idx_d   = nxt_idx_s;
            out_d   = mem_q[nxt_idx_s];
            valid_d = 1'b1;
         end else begin
            ps_d = ps_q + PS_ONE;
         end
      end else if (state_d == S_DONE) begin
         done_d = 1'b1;
      end else begin
         done_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         ps_q    <= PS_ZERO;
         dir_q   <= 1'b0;
         idx_q   <= IDX_ZERO;
         out_q   <= {DW{1'b0}};
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SEG7_EN
         seg_q   <= 7'h3F;
`endif
      end else begin
         state_q <= state_d;
         ps_q    <= ps_d;
         dir_q   <= dir_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SEG7_EN
         seg_q   <= seg_d;
`endif
      end
   end

   // Digit storage; writes are accepted in every state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DIGITS; i++) begin
            mem_q[i] <= {DW{1'b0}};
         end
      end else if (wr_ok_s) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign out       = out_q;
   assign idx       = idx_q;
   assign out_valid = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef SEG7_EN
   assign seg       = seg_q;
`endif

endmodule

// File: tb/tb_birthday_seq_display.sv
// -----------------------------------------------------------------------------
// Testbench for birthday_seq_display.
//   dut_a: DIGITS=8, PRESCALE=1   (main sequences, write/stop/reset cases)
//   dut_b: DIGITS=8, PRESCALE=3   (digit hold time)
//   dut_c: DIGITS=6, IDX_W=4      (dropped out-of-range writes, modulo-6 wrap)
// -----------------------------------------------------------------------------
module tb_birthday_seq_display;

   logic       CLK = 1'b0;
   logic       RST;
   logic       wr_en_ab, wr_en_c;
   logic [3:0] wr_addr;
   logic [3:0] wr_data;
   logic       start_a, start_b, start_c;
   logic       stop, dir, loop;

   logic [3:0] out_a, out_b, out_c;
   logic [2:0] idx_a, idx_b;
   logic [3:0] idx_c;
   logic       valid_a, valid_b, valid_c;
   logic       busy_a, busy_b, busy_c;
   logic       done_a, done_b, done_c;
`ifdef SEG7_EN
   logic [6:0] seg_a, seg_b, seg_c;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int pat[8]  = '{2, 0, 0, 1, 0, 5, 1, 2};

   typedef struct {
      int    dut;     // 0 = dut_a, 2 = dut_c
      int    start, stop, dir, loop;
      int    e_out, e_idx, e_valid, e_busy, e_done;
      string name;
   } vec_t;
   vec_t vecs[$];

   always #5 CLK = ~CLK;

   birthday_seq_display #(.DIGITS(8), .DW(4), .IDX_W(3), .PRESCALE(1)) dut_a (
      .CLK(CLK), .RST(RST), .wr_en(wr_en_ab), .wr_addr(wr_addr[2:0]), .wr_data(wr_data),
      .start(start_a), .stop(stop), .dir(dir), .loop(loop),
      .out(out_a), .idx(idx_a), .out_valid(valid_a), .busy(busy_a), .done(done_a)
`ifdef SEG7_EN
      , .seg(seg_a)
`endif
   );

   birthday_seq_display #(.DIGITS(8), .DW(4), .IDX_W(3), .PRESCALE(3)) dut_b (
      .CLK(CLK), .RST(RST), .wr_en(wr_en_ab), .wr_addr(wr_addr[2:0]), .wr_data(wr_data),
      .start(start_b), .stop(stop), .dir(dir), .loop(loop),
      .out(out_b), .idx(idx_b), .out_valid(valid_b), .busy(busy_b), .done(done_b)
`ifdef SEG7_EN
      , .seg(seg_b)
`endif
   );

   birthday_seq_display #(.DIGITS(6), .DW(4), .IDX_W(4), .PRESCALE(1)) dut_c (
      .CLK(CLK), .RST(RST), .wr_en(wr_en_c), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start_c), .stop(stop), .dir(dir), .loop(loop),
      .out(out_c), .idx(idx_c), .out_valid(valid_c), .busy(busy_c), .done(done_c)
`ifdef SEG7_EN
      , .seg(seg_c)
`endif
   );

   task automatic check(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // {out, idx, valid, busy, done} packed for one-shot comparison
   function automatic int pack(input int o, input int i, input int v, input int b, input int d);
      return (o << 8) | (i << 4) | (v << 2) | (b << 1) | d;
   endfunction

   task automatic push(input int du, input int st, input int sp, input int d, input int l,
                       input int eo, input int ei, input int ev, input int eb, input int ed,
                       input string nm);
      vec_t v;
      v.dut = du; v.start = st; v.stop = sp; v.dir = d; v.loop = l;
      v.e_out = eo; v.e_idx = ei; v.e_valid = ev; v.e_busy = eb; v.e_done = ed;
      v.name = nm;
      vecs.push_back(v);
   endtask

`ifdef SEG7_EN
   function automatic int seg_ref(input int v);
      int tab[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                      'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
      return tab[v & 15];
   endfunction
`endif

   initial begin
      int act;
      int n;
      int vcount;

      // ---------------- vector table ----------------
      // ascending one-shot; a start mid-run must be ignored
      push(0, 1, 0, 0, 0, pat[0], 0, 1, 1, 0, "asc");
      for (int i = 1; i < 8; i++) push(0, (i == 3) ? 1 : 0, 0, 0, 0, pat[i], i, 1, 1, 0, "asc");
      push(0, 0, 0, 0, 0, pat[7], 7, 0, 0, 1, "asc_done");
      push(0, 0, 0, 0, 0, pat[7], 7, 0, 0, 0, "asc_idle");
      // descending one-shot; dir flips back to 0 after start and must not matter
      push(0, 1, 0, 1, 0, pat[7], 7, 1, 1, 0, "desc");
      for (int i = 6; i >= 0; i--) push(0, 0, 0, 0, 0, pat[i], i, 1, 1, 0, "desc");
      push(0, 0, 0, 0, 0, pat[0], 0, 0, 0, 1, "desc_done");
      // restart from the DONE cycle in loop mode, 20 cycles, then drop loop
      for (int k = 0; k < 24; k++)
         push(0, (k == 0) ? 1 : 0, 0, 0, (k < 20) ? 1 : 0, pat[k % 8], k % 8, 1, 1, 0, "loop");
      push(0, 0, 0, 0, 0, pat[7], 7, 0, 0, 1, "loop_done");
      push(0, 1, 1, 0, 0, pat[7], 7, 0, 0, 0, "stop_beats_start");
      push(0, 0, 0, 0, 0, pat[7], 7, 0, 0, 0, "idle_hold");
      // DIGITS=6, descending loop: 5..0 wraps to 5, then one more pass and done
      for (int k = 0; k < 12; k++)
         push(2, (k == 0) ? 1 : 0, 0, 1, (k <= 6) ? 1 : 0, pat[5 - (k % 6)], 5 - (k % 6), 1, 1, 0, "d6_loop");
      push(2, 0, 0, 1, 0, pat[0], 0, 0, 0, 1, "d6_done");

      // ---------------- reset ----------------
      RST = 1'b1; wr_en_ab = 1'b0; wr_en_c = 1'b0; wr_addr = 4'd0; wr_data = 4'd0;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; stop = 1'b0; dir = 1'b0; loop = 1'b0;
      cyc(); cyc();
      check("reset_a", pack(int'(out_a), int'(idx_a), int'(valid_a), int'(busy_a), int'(done_a)), 0);
      check("reset_c", pack(int'(out_c), int'(idx_c), int'(valid_c), int'(busy_c), int'(done_c)), 0);
      check("reset_b_busy", int'(busy_b), 0);
`ifdef SEG7_EN
      check("reset_seg", int'(seg_a), 'h3F);
`endif
      RST = 1'b0;

      // ---------------- program slots ----------------
      for (int i = 0; i < 8; i++) begin
         wr_en_ab = 1'b1; wr_en_c = 1'b1; wr_addr = 4'(i); wr_data = 4'(pat[i]);
         cyc();
      end
      wr_en_ab = 1'b0; wr_addr = 4'd8; wr_data = 4'd9;   // out of range for dut_c
      cyc();
      wr_en_c = 1'b0;

      // ---------------- apply table ----------------
      vcount = 0;
      foreach (vecs[k]) begin
         start_a = (vecs[k].dut == 0) && (vecs[k].start != 0);
         start_c = (vecs[k].dut == 2) && (vecs[k].start != 0);
         stop    = (vecs[k].stop != 0);
         dir     = (vecs[k].dir != 0);
         loop    = (vecs[k].loop != 0);
         cyc();
         if (vecs[k].dut == 2)
            act = pack(int'(out_c), int'(idx_c), int'(valid_c), int'(busy_c), int'(done_c));
         else
            act = pack(int'(out_a), int'(idx_a), int'(valid_a), int'(busy_a), int'(done_a));
         check($sformatf("%s[%0d]", vecs[k].name, vcount), act,
               pack(vecs[k].e_out, vecs[k].e_idx, vecs[k].e_valid, vecs[k].e_busy, vecs[k].e_done));
`ifdef SEG7_EN
         if (vecs[k].dut == 0)
            check($sformatf("seg[%0d]", vcount), int'(seg_a), seg_ref(vecs[k].e_out));
`endif
         vcount++;
      end
      start_a = 1'b0; start_c = 1'b0; stop = 1'b0; loop = 1'b0; dir = 1'b0;

      // ---------------- PRESCALE=3 hold time ----------------
      start_b = 1'b1;
      cyc();
      start_b = 1'b0;
      check("ps3_first", pack(int'(out_b), int'(idx_b), int'(valid_b), int'(busy_b), int'(done_b)),
            pack(pat[0], 0, 1, 1, 0));
      n = 0;
      while (done_b !== 1'b1 && n < 40) begin
         cyc();
         n++;
         if (done_b !== 1'b1)
            check($sformatf("ps3_step%0d", n),
                  pack(int'(out_b), int'(idx_b), int'(valid_b), int'(busy_b), 0),
                  pack(pat[(n / 3) % 8], (n / 3) % 8, (n % 3 == 0) ? 1 : 0, 1, 0));
      end
      check("ps3_cycles_to_done", n, 24);
      check("ps3_busy_at_done", int'(busy_b), 0);

      // ---------------- write during RUN ----------------
      start_a = 1'b1; dir = 1'b0; loop = 1'b0;
      cyc();                                     // idx0
      start_a = 1'b0;
      cyc(); cyc(); cyc();                       // idx1..3
      check("wr_at_idx3", int'(idx_a), 3);
      wr_en_ab = 1'b1; wr_addr = 4'd5; wr_data = 4'd9;
      cyc();                                     // idx4, slot5 <= 9
      wr_en_ab = 1'b0;
      cyc();                                     // idx5
      check("wr_new_seen", pack(int'(out_a), int'(idx_a), 0, 0, 0), pack(9, 5, 0, 0, 0));
      wr_en_ab = 1'b1; wr_addr = 4'd6; wr_data = 4'd7;
      cyc();                                     // idx6 read and written together
      wr_en_ab = 1'b0;
      check("rd_before_wr", pack(int'(out_a), int'(idx_a), 0, 0, 0), pack(1, 6, 0, 0, 0));
      cyc(); cyc();                              // idx7, done
      check("wr_run_done", int'(done_a), 1);
      cyc();

      // ---------------- stop at idx 4 (descending) ----------------
      start_a = 1'b1; dir = 1'b1;
      cyc();                                     // idx7
      start_a = 1'b0; dir = 1'b0;
      cyc();                                     // idx6 now holds 7
      check("rbw_next_visit", pack(int'(out_a), int'(idx_a), 0, 0, 0), pack(7, 6, 0, 0, 0));
      cyc(); cyc();                              // idx5, idx4
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      check("stop", pack(int'(out_a), int'(idx_a), int'(valid_a), int'(busy_a), int'(done_a)),
            pack(0, 4, 0, 0, 0));
      cyc();
      check("stop_no_done", pack(int'(out_a), int'(idx_a), int'(valid_a), int'(busy_a), int'(done_a)),
            pack(0, 4, 0, 0, 0));

      // ---------------- RST mid-sequence at idx 4 ----------------
      start_a = 1'b1; dir = 1'b0;
      cyc();
      start_a = 1'b0;
      cyc(); cyc(); cyc(); cyc();
      check("pre_rst_idx", int'(idx_a), 4);
      RST = 1'b1;
      cyc();
      RST = 1'b0;
      check("rst_mid", pack(int'(out_a), int'(idx_a), int'(valid_a), int'(busy_a), int'(done_a)), 0);
      cyc();
      check("rst_no_done", pack(int'(out_a), int'(idx_a), int'(valid_a), int'(busy_a), int'(done_a)), 0);
      start_a = 1'b1;
      cyc();
      start_a = 1'b0;
      check("rst_cleared0", pack(int'(out_a), int'(idx_a), int'(valid_a), int'(busy_a), 0),
            pack(0, 0, 1, 1, 0));
      for (int i = 1; i < 8; i++) begin
         cyc();
         check($sformatf("rst_cleared%0d", i), pack(int'(out_a), int'(idx_a), 0, 0, 0), pack(0, i, 0, 0, 0));
      end
      cyc();
      check("rst_pass_done", int'(done_a), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
